rggen_axi4lite_to_apb_bridge: RTL

Protocol converter that sits directly upstream of the APB host interface of a generated register block. It accepts single AXI4-Lite read and write transactions from a host and replays each one as an APB3/APB4 setup/access transfer. The APB pready, prdata and pslverr signals are turned back into AXI4-Lite B/R responses. Only one transaction is outstanding at a time, with round-robin arbitration between reads and writes.

---
 rtl/rggen_rtl_pkg.sv | 25 ++
 rtl/rggen_axi4lite_to_apb_bridge.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rggen_rtl_pkg.sv
// Shared types for the rggen RTL blocks: transfer direction, AXI response
// codes and the state encoding of the AXI4-Lite to APB bridge.
package rggen_rtl_pkg;

    typedef enum logic {
        RGGEN_READ  = 1'b0,
        RGGEN_WRITE = 1'b1
    } rggen_direction;

    typedef enum logic [1:0] {
        RGGEN_OKAY   = 2'b00,
        RGGEN_EXOKAY = 2'b01,
        RGGEN_SLVERR = 2'b10,
        RGGEN_DECERR = 2'b11
    } rggen_axi_resp;

    typedef enum logic [2:0] {
        RGGEN_BRIDGE_IDLE   = 3'd0,
        RGGEN_BRIDGE_SETUP  = 3'd1,
        RGGEN_BRIDGE_ACCESS = 3'd2,
        RGGEN_BRIDGE_WRESP  = 3'd3,
        RGGEN_BRIDGE_RRESP  = 3'd4
    } rggen_bridge_state;

endpackage

// File: rtl/rggen_axi4lite_to_apb_bridge.sv
// AXI4-Lite to APB bridge. One transaction in flight at a time; reads and
// writes share the APB port with round-robin priority between them.
//
// Handshake rule: every channel transfers on the cycle where its valid and
// ready are both high. AW and W are granted together, combinationally, only
// in IDLE; B/R valid is held with stable payload until the host's ready.
module rggen_axi4lite_to_apb_bridge
    import rggen_rtl_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDRESS_WIDTH-1:0]  awaddr,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDRESS_WIDTH-1:0]  araddr,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      psel,
    output logic                      penable,
    output logic [ADDRESS_WIDTH-1:0]  paddr,
    output logic                      pwrite,
    output logic [DATA_WIDTH-1:0]     pwdata,
    output logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic                      pready,
    input  logic [DATA_WIDTH-1:0]     prdata,
    input  logic                      pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    rggen_bridge_state state;
    rggen_bridge_state state_next;
    rggen_direction    direction;
    logic              priority_write;
    logic              resp_error;
    logic              write_request;
    logic              read_request;
    logic              grant_write;
    logic              grant_read;

    // Grants are gated by rst_n so no handshake is offered while in reset.
    assign write_request = awvalid && wvalid;
    assign read_request  = arvalid;
    assign grant_write   = rst_n && (state == RGGEN_BRIDGE_IDLE) && write_request
                           && (priority_write || !read_request);
    assign grant_read    = rst_n && (state == RGGEN_BRIDGE_IDLE) && read_request
                           && (!priority_write || !write_request);

    assign awready = grant_write;
    assign wready  = grant_write;
    assign arready = grant_read;
    assign pwrite  = (direction == RGGEN_WRITE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RGGEN_BRIDGE_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and per-state APB/response strobes.
    always_comb begin
        state_next = state;
        psel       = 1'b0;
        penable    = 1'b0;
        bvalid     = 1'b0;
        rvalid     = 1'b0;
        bresp      = RGGEN_OKAY;
        rresp      = RGGEN_OKAY;
        case (state)
            RGGEN_BRIDGE_IDLE: begin
                if (grant_write || grant_read) begin
                    state_next = RGGEN_BRIDGE_SETUP;
                end
            end
            RGGEN_BRIDGE_SETUP: begin
                psel       = 1'b1;
                state_next = RGGEN_BRIDGE_ACCESS;
            end
            RGGEN_BRIDGE_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    state_next = (direction == RGGEN_WRITE) ? RGGEN_BRIDGE_WRESP
                                                            : RGGEN_BRIDGE_RRESP;
                end
            end
            RGGEN_BRIDGE_WRESP: begin
                bvalid = 1'b1;
                bresp  = resp_error ? RGGEN_SLVERR : RGGEN_OKAY;
                if (bready) begin
                    state_next = RGGEN_BRIDGE_IDLE;
                end
            end
            RGGEN_BRIDGE_RRESP: begin
                rvalid = 1'b1;
                rresp  = resp_error ? RGGEN_SLVERR : RGGEN_OKAY;
                if (rready) begin
                    state_next = RGGEN_BRIDGE_IDLE;
                end
            end
            default: begin
                state_next = RGGEN_BRIDGE_IDLE;
            end
        endcase
    end

    // Round-robin: the side that did not win holds priority next time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            priority_write <= 1'b1;
        end else if (grant_write) begin
            priority_write <= 1'b0;
        end else if (grant_read) begin
            priority_write <= 1'b1;
        end
    end

    // Latch the granted request; held stable through SETUP/ACCESS and idle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            paddr     <= '0;
            direction <= RGGEN_READ;
            pwdata    <= '0;
            pstrb     <= '0;
        end else if (grant_write) begin
            paddr     <= awaddr;
            direction <= RGGEN_WRITE;
            pwdata    <= wdata;
            pstrb     <= wstrb;
        end else if (grant_read) begin
            paddr     <= araddr;
            direction <= RGGEN_READ;
            pwdata    <= '0;
            pstrb     <= {STRB_WIDTH{1'b0}};
        end
    end

    // Capture the APB completion status and read data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata      <= '0;
            resp_error <= 1'b0;
        end else if ((state == RGGEN_BRIDGE_ACCESS) && pready) begin
            resp_error <= pslverr;
            if (direction == RGGEN_READ) begin
                rdata <= prdata;
            end
        end
    end

endmodule
